// File: rtl/jt12_cen_frac.sv
`default_nettype none
// ============================================================================
//  Module      : jt12_cen_frac
//  Description : Fractional clock-enable generator. A phase accumulator adds
//                num every enabled clk and fires cen when it reaches den,
//                giving an average cen rate of num/den. The ratio can be
//                reprogrammed at run time and is applied at a period boundary.
//                The optional half-rate enable (cen_half) is built only when
//                the macro JT12_CEN_HALF_EN is defined; otherwise it is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt12_cen_frac #(
    parameter int           W    = 16,
    parameter logic [W-1:0] NUM0 = {{(W-1){1'b0}}, 1'b1},
    parameter logic [W-1:0] DEN0 = {{(W-2){1'b0}}, 2'b10}
) (
    input  logic         clk,
    input  logic         rst0,
    input  logic         en,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_num,
    input  logic [W-1:0] cfg_den,
    output logic         cen,
    output logic         cen_half,
    output logic         cfg_pend,
    output logic         cfg_err
);

    logic [W-1:0] acc_q,  acc_d;
    logic [W-1:0] num_q,  num_d;
    logic [W-1:0] den_q,  den_d;
    logic [W-1:0] pnum_q, pnum_d;
    logic [W-1:0] pden_q, pden_d;
    logic         pend_q, pend_d;
    logic         cen_q,  cen_d;
    logic         err_q,  err_d;

    logic [W:0]   w_sum;
    logic         w_hit;
    logic         w_cfg_ok;

    // Phase accumulation, ratio apply and config validation.
    always_comb begin
        acc_d    = acc_q;
        num_d    = num_q;
        den_d    = den_q;
        pnum_d   = pnum_q;
        pden_d   = pden_q;
        pend_d   = pend_q;
        cen_d    = 1'b0;
        err_d    = 1'b0;

        // One extra bit so acc + num never wraps.
        w_sum    = {1'b0, acc_q} + {1'b0, num_q};
        w_hit    = (w_sum >= {1'b0, den_q});
        w_cfg_ok = (cfg_den != '0) && (cfg_num != '0) && (cfg_num <= cfg_den);

        if (en) begin
            cen_d = w_hit;
            // True difference is below den, so modular W-bit subtraction is exact.
            acc_d = w_hit ? (w_sum[W-1:0] - den_q) : w_sum[W-1:0];
            if (w_hit && pend_q) begin
                num_d  = pnum_q;
                den_d  = pden_q;
                acc_d  = '0;
                pend_d = 1'b0;
            end
        end else if (pend_q) begin
            // Stopped: nothing to align with, so the new ratio goes in at once.
            num_d  = pnum_q;
            den_d  = pden_q;
            acc_d  = '0;
            pend_d = 1'b0;
        end

        // A request in the apply cycle becomes the next pending ratio.
        if (cfg_we) begin
            if (w_cfg_ok) begin
                pnum_d = cfg_num;
                pden_d = cfg_den;
                pend_d = 1'b1;
            end else begin
                err_d  = 1'b1;
            end
        end
    end

    // Main state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst0) begin
        if (rst0) begin
            acc_q  <= '0;
            num_q  <= NUM0;
            den_q  <= DEN0;
            pnum_q <= '0;
            pden_q <= '0;
            pend_q <= 1'b0;
            cen_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            num_q  <= num_d;
            den_q  <= den_d;
            pnum_q <= pnum_d;
            pden_q <= pden_d;
            pend_q <= pend_d;
            cen_q  <= cen_d;
            err_q  <= err_d;
        end
    end

    assign cen      = cen_q;
    assign cfg_pend = pend_q;
    assign cfg_err  = err_q;

`ifdef JT12_CEN_HALF_EN
    logic tog_q,  tog_d;
    logic half_q, half_d;

    // Toggle on every cen; the half pulse marks the 1->0 transition.
    always_comb begin
        tog_d  = tog_q;
        half_d = 1'b0;
        if (cen_d) begin
            tog_d  = ~tog_q;
            half_d = tog_q;
        end
    end

    // Half-rate toggle register with asynchronous reset.
    always_ff @(posedge clk or posedge rst0) begin
        if (rst0) begin
            tog_q  <= 1'b0;
            half_q <= 1'b0;
        end else begin
            tog_q  <= tog_d;
            half_q <= half_d;
        end
    end

    assign cen_half = half_q;
`else
    assign cen_half = 1'b0;
`endif

endmodule
`default_nettype wire
